// File: rtl/ms_wr_buffer_if.sv
// Bundle of producer handshake, bus address/data phase and FIFO status
// signals for the buffered write-command source.
interface ms_wr_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  // Producer side
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;

  // Bus side
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          out_valid;
  logic          sready;

  // Status
  logic          full;
  logic          empty;
  logic [LW-1:0] level;

  // Buffer view: takes commands and sready, drives everything else
  modport master (
    input  in_valid, in_addr, in_data, sready,
    output in_ready, addr, data, out_valid, full, empty, level
  );

  // Environment view: producer plus slave
  modport slave (
    output in_valid, in_addr, in_data, sready,
    input  in_ready, addr, data, out_valid, full, empty, level
  );
endinterface

// File: rtl/ms_wr_buffer.sv
// Buffered write-command source: a DEPTH-entry FIFO feeding a single output
// register that presents the address phase, with data following one cycle
// after the slave accepts the address.
module ms_wr_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = 8
) (
  input  logic clk,
  input  logic rstn,
  ms_wr_buffer_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = AW + DW;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [DW-1:0] data_q, data_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          accept;
  logic [EW-1:0] head;

  // Occupancy flags come straight from the registered count, so in_ready
  // never depends on in_valid and no bypass from a same-cycle pop exists.
  assign full   = (level_q == LW'(DEPTH));
  assign empty  = (level_q == '0);
  assign push   = bus.in_valid && !full;
  assign accept = out_valid_q && bus.sready;
  assign pop    = (!out_valid_q || bus.sready) && !empty;
  assign head   = mem_q[rd_ptr_q];

  // Next-state for pointers, occupancy and the address/data phase registers
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_valid_d = out_valid_q;
    addr_d      = addr_q;
    hold_d      = hold_q;
    data_d      = data_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Completion hands the held data to the data phase before any reload
    if (accept) data_d = hold_q;

    if (pop) begin
      addr_d      = head[EW-1:DW];
      hold_d      = head[DW-1:0];
      out_valid_d = 1'b1;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
  end

  // Control and output-stage registers; reset discards everything in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      addr_q      <= '0;
      hold_q      <= '0;
      data_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      addr_q      <= addr_d;
      hold_q      <= hold_d;
      data_q      <= data_d;
    end
  end

  // FIFO storage, written on push only and never reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.in_addr, bus.in_data};
  end

  assign bus.in_ready  = !full;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.level     = level_q;
  assign bus.addr      = addr_q;
  assign bus.data      = data_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_ms_wr_buffer.sv
// Self-checking bench for ms_wr_buffer: directed scenarios plus random
// traffic, checked against a queue-based reference of the buffer.
module tb_ms_wr_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int VW    = 1 + AW + DW + LW + 3;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_t;

  logic clk = 1'b0;
  logic rstn;

  ms_wr_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  ms_wr_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int nt = 0;
  int nf = 0;

  // Reference: queued commands plus the visible address/data phase
  cmd_t          mq[$];
  logic          mv;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mhold;
  logic [DW-1:0] mdata;
  cmd_t          push_log[$];
  cmd_t          out_log[$];

  task automatic model_reset();
    mq.delete();
    mv    = 1'b0;
    maddr = '0;
    mhold = '0;
    mdata = '0;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic f;
    f = (mq.size() == DEPTH);
    return {mv, maddr, mdata, LW'(mq.size()), f, (mq.size() == 0), !f};
  endfunction

  function automatic logic [VW-1:0] act_vec();
    return {bus.out_valid, bus.addr, bus.data, bus.level,
            bus.full, bus.empty, bus.in_ready};
  endfunction

  // One clock: advance the reference by the buffer's rules, log traffic
  task automatic cycle();
    bit            do_push;
    bit            acc;
    bit            do_pop;
    bit            dut_acc;
    logic [AW-1:0] acc_addr;
    cmd_t          c;
    do_push  = bus.in_valid && (mq.size() < DEPTH);
    acc      = mv && bus.sready;
    do_pop   = (!mv || bus.sready) && (mq.size() > 0);
    dut_acc  = bus.out_valid && bus.sready;
    acc_addr = bus.addr;
    @(posedge clk);
    if (acc) mdata = mhold;
    if (do_pop) begin
      c     = mq.pop_front();
      maddr = c.a;
      mhold = c.d;
      mv    = 1'b1;
    end else if (acc) begin
      mv = 1'b0;
    end
    if (do_push) begin
      c.a = bus.in_addr;
      c.d = bus.in_data;
      mq.push_back(c);
      push_log.push_back(c);
    end
    #1;
    if (dut_acc) begin
      c.a = acc_addr;
      c.d = bus.data;
      out_log.push_back(c);
    end
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    bus.sready   = 1'b1;
    repeat (DEPTH + 3) cycle();
  endtask

  task automatic test_reset();
    rstn         = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    bus.sready   = 1'b0;
    model_reset();
    #2;
    nt++;
    if (act_vec() !== {1'b0, AW'(0), DW'(0), LW'(0), 1'b0, 1'b1, 1'b1}) begin
      nf++;
      $display("FAIL reset_values: got %h expected %h", act_vec(),
               {1'b0, AW'(0), DW'(0), LW'(0), 1'b0, 1'b1, 1'b1});
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) begin
      cycle();
      nt++;
      if (act_vec() !== exp_vec()) begin
        nf++;
        $display("FAIL reset_idle: got %h expected %h", act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single();
    push_log.delete();
    out_log.delete();
    bus.sready   = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_addr  = 2'd2;
    bus.in_data  = 8'h5A;
    cycle();
    bus.in_valid = 1'b0;
    nt++;
    if (bus.level !== LW'(1) || bus.out_valid !== 1'b0) begin
      nf++;
      $display("FAIL single_push: got level=%0d ov=%b expected level=1 ov=0",
               bus.level, bus.out_valid);
    end
    cycle();
    nt++;
    if (bus.out_valid !== 1'b1 || bus.addr !== 2'd2 || bus.level !== LW'(0)) begin
      nf++;
      $display("FAIL single_addr: got ov=%b addr=%0d level=%0d expected ov=1 addr=2 level=0",
               bus.out_valid, bus.addr, bus.level);
    end
    cycle();
    nt++;
    if (bus.data !== 8'h5A || bus.out_valid !== 1'b0 || bus.level !== LW'(0)) begin
      nf++;
      $display("FAIL single_data: got data=%h ov=%b level=%0d expected data=5a ov=0 level=0",
               bus.data, bus.out_valid, bus.level);
    end
    nt++;
    if (act_vec() !== exp_vec()) begin
      nf++;
      $display("FAIL single_model: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_fill();
    cmd_t exp_seq[5];
    exp_seq[0] = {2'd0, 8'h10};
    exp_seq[1] = {2'd1, 8'h20};
    exp_seq[2] = {2'd2, 8'h30};
    exp_seq[3] = {2'd3, 8'h40};
    exp_seq[4] = {2'd0, 8'hEE};
    push_log.delete();
    out_log.delete();
    bus.sready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_addr  = exp_seq[i].a;
      bus.in_data  = exp_seq[i].d;
      cycle();
    end
    nt++;
    if (bus.level !== LW'(3) || bus.full !== 1'b0) begin
      nf++;
      $display("FAIL fill_level3: got level=%0d full=%b expected level=3 full=0",
               bus.level, bus.full);
    end
    bus.in_addr = exp_seq[4].a;
    bus.in_data = exp_seq[4].d;
    cycle();
    nt++;
    if (bus.level !== LW'(4) || bus.full !== 1'b1 || bus.in_ready !== 1'b0) begin
      nf++;
      $display("FAIL fill_full: got level=%0d full=%b in_ready=%b expected 4 1 0",
               bus.level, bus.full, bus.in_ready);
    end
    bus.in_addr = 2'd1;
    bus.in_data = 8'h77;
    cycle();
    nt++;
    if (act_vec() !== exp_vec() || bus.level !== LW'(4)) begin
      nf++;
      $display("FAIL fill_ignored: got %h expected %h", act_vec(), exp_vec());
    end
    bus.in_valid = 1'b0;
    bus.sready   = 1'b1;
    repeat (5) cycle();
    nt++;
    if (out_log.size() != 5) begin
      nf++;
      $display("FAIL fill_rate: got %0d transfers expected 5", out_log.size());
    end
    for (int i = 0; i < 5 && i < out_log.size(); i++) begin
      nt++;
      if (out_log[i] !== exp_seq[i]) begin
        nf++;
        $display("FAIL fill_order[%0d]: got %h expected %h", i, out_log[i], exp_seq[i]);
      end
    end
    drain();
  endtask

  task automatic test_sready_toggle();
    bit                  pat[4];
    bit                  stall;
    logic [AW+DW:0]      prev;
    int                  sent;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    push_log.delete();
    out_log.delete();
    sent = 0;
    for (int k = 0; k < 24; k++) begin
      bus.sready = pat[k % 4];
      if (sent < 8 && bus.in_ready) begin
        bus.in_valid = 1'b1;
        bus.in_addr  = AW'($urandom);
        bus.in_data  = DW'($urandom);
        sent++;
      end else begin
        bus.in_valid = 1'b0;
      end
      stall = bus.out_valid && !bus.sready;
      prev  = {bus.out_valid, bus.addr, bus.data};
      cycle();
      if (stall) begin
        nt++;
        if ({bus.out_valid, bus.addr, bus.data} !== prev) begin
          nf++;
          $display("FAIL toggle_hold: got %h expected %h",
                   {bus.out_valid, bus.addr, bus.data}, prev);
        end
      end
      nt++;
      if (act_vec() !== exp_vec()) begin
        nf++;
        $display("FAIL toggle_model: got %h expected %h", act_vec(), exp_vec());
      end
    end
    drain();
    nt++;
    if (out_log.size() != push_log.size()) begin
      nf++;
      $display("FAIL toggle_count: got %0d expected %0d", out_log.size(), push_log.size());
    end
    for (int i = 0; i < out_log.size() && i < push_log.size(); i++) begin
      nt++;
      if (out_log[i] !== push_log[i]) begin
        nf++;
        $display("FAIL toggle_order[%0d]: got %h expected %h", i, out_log[i], push_log[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    push_log.delete();
    out_log.delete();
    bus.sready = 1'b0;
    repeat (3) begin
      bus.in_valid = 1'b1;
      bus.in_addr  = AW'($urandom);
      bus.in_data  = DW'($urandom);
      cycle();
    end
    nt++;
    if (bus.level !== LW'(2)) begin
      nf++;
      $display("FAIL b2b_prime: got level=%0d expected 2", bus.level);
    end
    bus.sready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = 1'b1;
      bus.in_addr  = AW'($urandom);
      bus.in_data  = DW'($urandom);
      cycle();
      nt++;
      if (bus.level !== LW'(2) || bus.out_valid !== 1'b1) begin
        nf++;
        $display("FAIL b2b_level: got level=%0d ov=%b expected level=2 ov=1",
                 bus.level, bus.out_valid);
      end
    end
    drain();
    nt++;
    if (out_log.size() != 13 || push_log.size() != 13) begin
      nf++;
      $display("FAIL b2b_count: got out=%0d in=%0d expected 13", out_log.size(), push_log.size());
    end
    for (int i = 0; i < out_log.size() && i < push_log.size(); i++) begin
      nt++;
      if (out_log[i] !== push_log[i]) begin
        nf++;
        $display("FAIL b2b_order[%0d]: got %h expected %h", i, out_log[i], push_log[i]);
      end
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    push_log.delete();
    out_log.delete();
    for (int k = 0; k < 400; k++) begin
      bus.in_valid = ($urandom_range(9) < 7);
      bus.in_addr  = AW'($urandom);
      bus.in_data  = DW'($urandom);
      bus.sready   = ($urandom_range(9) < 6);
      cycle();
      nt++;
      if (act_vec() !== exp_vec()) begin
        nf++;
        errs++;
        if (errs < 10)
          $display("FAIL random_model @%0d: got %h expected %h", k, act_vec(), exp_vec());
      end
    end
    drain();
    nt++;
    if (out_log.size() != push_log.size()) begin
      nf++;
      $display("FAIL random_count: got %0d expected %0d", out_log.size(), push_log.size());
    end
    for (int i = 0; i < out_log.size() && i < push_log.size(); i++) begin
      nt++;
      if (out_log[i] !== push_log[i]) begin
        nf++;
        $display("FAIL random_order[%0d]: got %h expected %h", i, out_log[i], push_log[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    bus.sready = 1'b0;
    repeat (4) begin
      bus.in_valid = 1'b1;
      bus.in_addr  = AW'($urandom_range(3, 1));
      bus.in_data  = DW'($urandom_range(255, 1));
      cycle();
    end
    bus.in_valid = 1'b0;
    nt++;
    if (bus.level !== LW'(3) || bus.out_valid !== 1'b1) begin
      nf++;
      $display("FAIL areset_prime: got level=%0d ov=%b expected 3 1", bus.level, bus.out_valid);
    end
    #2;
    rstn = 1'b0;
    #1;
    nt++;
    if (act_vec() !== {1'b0, AW'(0), DW'(0), LW'(0), 1'b0, 1'b1, 1'b1}) begin
      nf++;
      $display("FAIL areset_values: got %h expected %h", act_vec(),
               {1'b0, AW'(0), DW'(0), LW'(0), 1'b0, 1'b1, 1'b1});
    end
    model_reset();
    #2;
    rstn       = 1'b1;
    bus.sready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      nt++;
      if (bus.out_valid !== 1'b0 || bus.addr !== AW'(0) || bus.level !== LW'(0)) begin
        nf++;
        $display("FAIL areset_stale: got ov=%b addr=%0d level=%0d expected 0 0 0",
                 bus.out_valid, bus.addr, bus.level);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_sready_toggle();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule
